add_seq_ctrl: RTL and testbench
===============================

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 4, operand width in bytes (legal 2..8).
REQ-002 SHALL have port clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  controller can accept operands.
REQ-006 SHALL have port a  input  8*NUM_BYTES  operand A.
REQ-007 SHALL have port b  input  8*NUM_BYTES  operand B.
REQ-008 SHALL have port cin  input  1  carry-in of the wide add.
REQ-009 SHALL have port sub  input  1  subtract request (honoured only with ADD_SEQ_SUB_EN).
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  8*NUM_BYTES  wide result.
REQ-013 SHALL have port cout  output  1  carry-out of the most significant byte.

Function
REQ-014 SHALL compute sum/cout = a + b + cin (mod 2^(8*NUM_BYTES)) using one shared 8-bit adder, one byte per clock, LSB first.
REQ-015 SHALL implement FSM IDLE, RUN, DONE; in_ready = (state==IDLE), out_valid = (state==DONE), both registered-state decodes.
REQ-016 IDLE: on in_valid&&in_ready at an edge, SHALL latch a, b, cin, sub, clear byte index to 0, set carry register = effective carry-in, go RUN.
REQ-017 RUN: each edge SHALL write adder sum into sum byte[idx], carry register <= adder Cout, idx <= idx+1; at idx==NUM_BYTES-1 go DONE and load cout.
REQ-018 Latency: out_valid SHALL assert exactly NUM_BYTES cycles after the accepting edge; throughput one operation per NUM_BYTES+1 cycles minimum.
REQ-019 DONE: sum/cout SHALL hold stable while out_valid && !out_ready; on out_ready go IDLE.
REQ-020 in_valid during RUN/DONE SHALL be ignored (not latched); changes on a/b after acceptance SHALL not affect the result.
REQ-021 sum and cout SHALL keep the last result in IDLE until the next operation overwrites them byte by byte.
REQ-022 Boundary: all-ones + 0 + cin=1 SHALL yield sum=0, cout=1 (carry ripples across every byte); all-ones + all-ones SHALL yield sum=all-ones-minus-1, cout=1.
REQ-023 idx counter width SHALL be $clog2(NUM_BYTES) bits and never exceed NUM_BYTES-1.

Reset
REQ-024 rst high SHALL asynchronously force state=IDLE, idx=0, carry=0, sum=0, cout=0, hence in_ready=1, out_valid=0.
REQ-025 rst asserted mid-RUN or in DONE SHALL abort the operation; no partial result is reported after release.
REQ-026 First acceptance SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro ADD_SEQ_SUB_EN: defined -> when latched sub=1, B bytes SHALL be inverted at the adder input and effective carry-in forced to 1 (result a-b, cout=1 means no borrow), cin ignored.
REQ-028 ADD_SEQ_SUB_EN undefined -> sub port SHALL exist but be ignored; no inversion logic synthesized.

Structure
REQ-029 Shared package add_seq_pkg SHALL hold the FSM state enum typedef (IDLE/RUN/DONE) and the BYTE_W=8 constant.
REQ-030 The byte-wide datapath SHALL be one instance of the existing ripple_carry_8_bit_adder (ports S, Cout, A, B, Cin); the controller contains no other adder.

Verification
REQ-031 Reset then NUM_BYTES=4, a=0x00000001, b=0x00000001, cin=0 -> out_valid 4 cycles after accept, sum=0x00000002, cout=0.
REQ-032 a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1 (full ripple).
REQ-033 a=0x00FF00FF, b=0x00010001, cin=0, out_ready held low 5 cycles -> sum=0x01000100, cout=0 held stable, in_ready=0 throughout, in_valid pulses ignored.
REQ-034 rst asserted 2 cycles into RUN of a=0xFFFFFFFF, b=0xFFFFFFFF -> immediate IDLE, sum=0, out_valid never asserts; next op a=0x12345678, b=0x11111111 -> sum=0x23456789.
REQ-035 With ADD_SEQ_SUB_EN: a=0x00000005, b=0x00000007, sub=1 -> sum=0xFFFFFFFE, cout=0; a=7, b=5, sub=1 -> sum=0x00000002, cout=1.
REQ-036 Back-to-back: in_valid held high, out_ready high -> accepts every NUM_BYTES+1 cycles, each result matching a golden model.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the byte-serial add controller.
package add_seq_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/ripple_carry_8_bit_adder.sv
// 8-bit ripple-carry adder used as the shared byte datapath of add_seq_ctrl.
module ripple_carry_8_bit_adder (
   output logic [7:0] S,
   output logic       Cout,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Cin
);

   logic c;

   always_comb begin
      S = '0;
      c = Cin;
      for (int unsigned i = 0; i < 8; i++) begin
         S[i] = A[i] ^ B[i] ^ c;
         c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
      end
      Cout = c;
   end

endmodule

// File: rtl/add_seq_ctrl.sv
// Byte-serial wide adder: one shared 8-bit adder, one byte per clock, LSB first.
// Optional subtract support is enabled by defining ADD_SEQ_SUB_EN.
module add_seq_ctrl
   import add_seq_pkg::*;
#(
   parameter int unsigned NUM_BYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NUM_BYTES-1:0] a,
   input  logic [8*NUM_BYTES-1:0] b,
   input  logic                  cin,
   input  logic                  sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NUM_BYTES-1:0] sum,
   output logic                  cout
);

   localparam int unsigned W     = BYTE_W * NUM_BYTES;
   localparam int unsigned IDX_W = $clog2(NUM_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             cout_q, cout_d;

   logic [BYTE_W-1:0] a_byte, b_byte, b_add, adder_s;
   logic              adder_cout;
   logic              cin_eff;

   assign a_byte = a_q[idx_q*BYTE_W +: BYTE_W];
   assign b_byte = b_q[idx_q*BYTE_W +: BYTE_W];

`ifdef ADD_SEQ_SUB_EN
   logic sub_q, sub_d;

   // Subtract is a + ~b + 1; the latched sub overrides cin for the whole op.
   assign cin_eff = sub ? 1'b1 : cin;
   assign b_add   = sub_q ? ~b_byte : b_byte;
   assign sub_d   = (state_q == IDLE && in_valid) ? sub : sub_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sub_q <= 1'b0;
      else     sub_q <= sub_d;
   end
`else
   logic sub_unused;

   assign sub_unused = sub;
   assign cin_eff    = cin;
   assign b_add      = b_byte;
`endif

   ripple_carry_8_bit_adder u_adder (
      .S    (adder_s),
      .Cout (adder_cout),
      .A    (a_byte),
      .B    (b_add),
      .Cin  (carry_q)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               idx_d   = '0;
               carry_d = cin_eff;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q*BYTE_W +: BYTE_W] = adder_s;
            carry_d = adder_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = adder_cout;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl (NUM_BYTES=4): driver pushes expectations, monitor pops on out_valid.
module tb_add_seq_ctrl;

   localparam int unsigned NB  = 4;
   localparam int unsigned W   = 8 * NB;
   localparam int unsigned LAT = NB;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      int           acc_cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout;

   exp_t sb_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   bit   seen   = 1'b0;

   add_seq_ctrl #(.NUM_BYTES(NB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // Monitor: compares the first cycle of each out_valid window against the scoreboard.
   always @(negedge clk) begin
      if (rst || !out_valid) begin
         seen = 1'b0;
      end else if (!seen) begin
         exp_t e;
         seen = 1'b1;
         if (sb_q.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("sum", 64'(sum), 64'(e.sum));
            check("cout", 64'(cout), 64'(e.cout));
            check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
         end
      end
   end

   function automatic logic [W:0] golden(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   // Drives one request at a negedge, waits for acceptance, then scrambles inputs.
   task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic vs, input logic [W-1:0] es, input logic ec, input bit expect_result);
      int n;
      exp_t e;
      n = 0;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         timeout("accept_wait");
         return;
      end
      a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
      if (expect_result) begin
         e.sum = es; e.cout = ec; e.acc_cyc = cyc + 1;
         sb_q.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = ~vc; sub = ~vs;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (!(sb_q.size() == 0 && in_ready && !out_valid) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) timeout("drain");
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      rst = 1'b0;

      // Accepted on the very first edge after reset release.
      do_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b1);
      drain();
      do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
      drain();

      // Stall: result must hold and in_valid pulses must be ignored.
      out_ready = 1'b0;
      do_op(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b1);
      begin
         int n;
         n = 0;
         while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (!out_valid) timeout("stall_wait");
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         a = 32'hAAAA_AAAA; b = 32'h5555_5555;
         @(negedge clk);
         check("stall_sum", 64'(sum), 64'h0100_0100);
         check("stall_cout", 64'(cout), 64'd0);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_out_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      check("idle_hold_sum", 64'(sum), 64'h0100_0100);

      // Abort mid-RUN: no result may surface afterwards.
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_in_ready", 64'(in_ready), 64'd1);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_sum", 64'(sum), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("abort_quiet", 64'(out_valid), 64'd0);
      do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b1);
      drain();

      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b1);
      drain();

`ifdef ADD_SEQ_SUB_EN
      do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
      drain();
      do_op(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b1);
      drain();
`else
      do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b1);
      drain();
`endif

      // Back-to-back with in_valid held high; expectations from the golden model.
      begin
         logic [W-1:0] va[5] = '{32'h8000_0000, 32'h0000_FFFF, 32'hDEAD_BEEF, 32'h7FFF_FFFF, 32'h0F0F_0F0F};
         logic [W-1:0] vb[5] = '{32'h8000_0000, 32'h0000_0001, 32'h0101_0101, 32'h0000_0000, 32'hF0F0_F0F0};
         logic         vc[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
         int k, n;
         k = 0; n = 0;
         in_valid = 1'b1;
         sub = 1'b0;
         while (k < 5 && n < 100) begin
            if (in_ready) begin
               exp_t e;
               logic [W:0] g;
               a = va[k]; b = vb[k]; cin = vc[k];
               g = golden(va[k], vb[k], vc[k]);
               e.sum = g[W-1:0]; e.cout = g[W]; e.acc_cyc = cyc + 1;
               sb_q.push_back(e);
               k++;
            end
            @(negedge clk);
            n++;
         end
         if (k < 5) timeout("b2b_accept");
         in_valid = 1'b0;
         drain();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
